// File: rtl/seq_detect_fsm.sv
// Moore serial pattern detector: the state is the longest matched pattern prefix.
// Transitions come from a KMP table built at elaboration; a saturating counter tallies matches.
module seq_detect_fsm #(
    parameter int                 PAT_LEN   = 4,
    parameter logic [PAT_LEN-1:0] PATTERN   = 4'b1011,
    parameter int                 OVERLAP   = 1,
    parameter int                 CNT_WIDTH = 8,
    parameter int                 ST_WIDTH  = $clog2(PAT_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 x,
    input  logic                 clr_cnt,
    output logic [ST_WIDTH-1:0]  state,
    output logic                 match,
    output logic [CNT_WIDTH-1:0] match_cnt
);

    localparam int NUM_ENT = 2 * (PAT_LEN + 1);
    localparam int TBL_W   = NUM_ENT * ST_WIDTH;
    localparam int IDX_W   = ST_WIDTH + 1;

    localparam logic [ST_WIDTH-1:0] S_EMPTY = '0;
    localparam logic [ST_WIDTH-1:0] S_FULL  = ST_WIDTH'(PAT_LEN);

    if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_param
        $fatal(1, "seq_detect_fsm: PAT_LEN must be in 2..16");
    end

    // Entry {k, b} is the longest pattern prefix that is a suffix of (prefix_k followed by b).
    function automatic logic [TBL_W-1:0] build_table();
        logic [TBL_W-1:0]   tbl;
        logic [PAT_LEN-1:0] sh_s;
        logic [PAT_LEN-1:0] sh_p;
        int                 best;
        int                 m;
        bit                 ok;
        bit                 sb;
        tbl = '0;
        for (int k = 0; k <= PAT_LEN; k++) begin
            for (int b = 0; b < 2; b++) begin
                best = 0;
                for (int j = 1; j <= PAT_LEN; j++) begin
                    if (j <= k + 1) begin
                        ok = 1'b1;
                        for (int t = 0; t < j; t++) begin
                            m = k + 1 - j + t;
                            if (m < k) begin
                                sh_s = PATTERN >> (PAT_LEN - 1 - m);
                                sb   = sh_s[0];
                            end else begin
                                sb = (b != 0);
                            end
                            sh_p = PATTERN >> (PAT_LEN - 1 - t);
                            if (sb != sh_p[0]) ok = 1'b0;
                        end
                        if (ok) best = j;
                    end
                end
                tbl = tbl | (TBL_W'(best) << ((k * 2 + b) * ST_WIDTH));
            end
        end
        return tbl;
    endfunction

    localparam logic [TBL_W-1:0] DELTA_TBL = build_table();

    logic [ST_WIDTH-1:0]  w_tbl [2**IDX_W];
    logic [ST_WIDTH-1:0]  w_state_eff;
    logic [ST_WIDTH-1:0]  w_next;
    logic                 w_hit;
    logic [ST_WIDTH-1:0]  r_state;
    logic [CNT_WIDTH-1:0] r_cnt;

    for (genvar g = 0; g < 2**IDX_W; g++) begin : g_tbl
        if (g < NUM_ENT) begin : g_used
            assign w_tbl[g] = DELTA_TBL[g*ST_WIDTH +: ST_WIDTH];
        end else begin : g_unused
            assign w_tbl[g] = S_EMPTY;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_eff = r_state;
        if (OVERLAP == 0 && r_state == S_FULL) w_state_eff = S_EMPTY;
        w_next = w_tbl[{w_state_eff, x}];
        w_hit  = en && (w_next == S_FULL);
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else if (en) begin
            r_state <= w_next;
        end
    end

    // Clear wins over a coincident increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            r_cnt <= '0;
        end else if (w_hit && r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    assign state     = r_state;
    assign match     = (r_state == S_FULL);
    assign match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Self-checking bench for seq_detect_fsm: directed vector table, saturation/clear sequence,
// and randomized streams compared against a suffix-matching reference model.
module tb_seq_detect_fsm;

    localparam int NDUT = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic x   = 1'b0;
    logic clr = 1'b0;

    logic [2:0] st0, st1, st2, st3, st4;
    logic       m0, m1, m2, m3, m4;
    logic [7:0] c0, c1, c2;
    logic [1:0] c3;
    logic [3:0] c4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_detect_fsm #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_WIDTH(8)) u0 (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr),
        .state(st0), .match(m0), .match_cnt(c0));
    seq_detect_fsm #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_WIDTH(8)) u1 (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr),
        .state(st1), .match(m1), .match_cnt(c1));
    seq_detect_fsm #(.PAT_LEN(4), .PATTERN(4'b1111), .OVERLAP(1), .CNT_WIDTH(8)) u2 (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr),
        .state(st2), .match(m2), .match_cnt(c2));
    seq_detect_fsm #(.PAT_LEN(4), .PATTERN(4'b1111), .OVERLAP(1), .CNT_WIDTH(2)) u3 (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr),
        .state(st3), .match(m3), .match_cnt(c3));
    seq_detect_fsm #(.PAT_LEN(6), .PATTERN(6'b101101), .OVERLAP(1), .CNT_WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr),
        .state(st4), .match(m4), .match_cnt(c4));

    // Configuration of each instance, as seen by the reference model.
    function automatic int cfg_len(int i);
        return (i == 4) ? 6 : 4;
    endfunction
    function automatic int unsigned cfg_pat(int i);
        case (i)
            0, 1:    return 32'hB;
            2, 3:    return 32'hF;
            default: return 32'h2D;
        endcase
    endfunction
    function automatic bit cfg_ovl(int i);
        return (i != 1);
    endfunction
    function automatic int cfg_cmax(int i);
        case (i)
            3:       return 3;
            4:       return 15;
            default: return 255;
        endcase
    endfunction

    function automatic logic [31:0] d_state(int i);
        case (i)
            0:       return 32'(st0);
            1:       return 32'(st1);
            2:       return 32'(st2);
            3:       return 32'(st3);
            default: return 32'(st4);
        endcase
    endfunction
    function automatic logic [31:0] d_match(int i);
        case (i)
            0:       return 32'(m0);
            1:       return 32'(m1);
            2:       return 32'(m2);
            3:       return 32'(m3);
            default: return 32'(m4);
        endcase
    endfunction
    function automatic logic [31:0] d_cnt(int i);
        case (i)
            0:       return 32'(c0);
            1:       return 32'(c1);
            2:       return 32'(c2);
            3:       return 32'(c3);
            default: return 32'(c4);
        endcase
    endfunction

    // Reference model: the last sampled bits (newest in bit 0) since reset, or since the
    // last match when overlap is off; state is the longest suffix equal to a pattern prefix.
    int unsigned m_hist  [NDUT];
    int          m_hl    [NDUT];
    int          m_state [NDUT];
    int          m_cnt   [NDUT];

    task automatic model_edge(input bit r, input bit e, input bit b, input bit c);
        int unsigned mask;
        int unsigned pre;
        int          len;
        int          k;
        for (int i = 0; i < NDUT; i++) begin
            len = cfg_len(i);
            if (r) begin
                m_hist[i] = 0; m_hl[i] = 0; m_state[i] = 0; m_cnt[i] = 0;
            end else begin
                k = m_state[i];
                if (e) begin
                    if (!cfg_ovl(i) && m_state[i] == len) m_hl[i] = 0;
                    m_hist[i] = (m_hist[i] << 1) | 32'(b);
                    if (m_hl[i] < 16) m_hl[i]++;
                    k = 0;
                    for (int j = 1; j <= len; j++) begin
                        mask = (32'd1 << j) - 1;
                        pre  = cfg_pat(i) >> (len - j);
                        if (j <= m_hl[i] && ((m_hist[i] ^ pre) & mask) == 0) k = j;
                    end
                end
                if (c) m_cnt[i] = 0;
                else if (e && k == len && m_cnt[i] < cfg_cmax(i)) m_cnt[i]++;
                m_state[i] = k;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive on the falling edge, let the model see the rising edge, sample 1 ns later.
    task automatic step(input bit r, input bit e, input bit b, input bit c);
        @(negedge clk);
        rst = r; en = e; x = b; clr = c;
        @(posedge clk);
        model_edge(r, e, b, c);
        #1;
    endtask

    typedef struct {
        bit r, e, b, c;
        int s0, n0, s1, n1;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, e, b, c, input int s0, n0, s1, n1);
        vec_t v;
        v.r = r; v.e = e; v.b = b; v.c = c;
        v.s0 = s0; v.n0 = n0; v.s1 = s1; v.n1 = n1;
        tbl.push_back(v);
    endtask

    initial begin
        // rst, en, x, clr | u0 state/cnt (overlap) | u1 state/cnt (no overlap)
        add(1,0,0,0, 0,0, 0,0);
        add(1,0,0,0, 0,0, 0,0);
        add(0,1,1,0, 1,0, 1,0);
        add(0,1,0,0, 2,0, 2,0);
        add(0,1,1,0, 3,0, 3,0);
        add(0,1,1,0, 4,1, 4,1);
        add(0,1,0,0, 2,1, 0,1);
        add(0,1,1,0, 3,1, 1,1);
        add(0,1,1,0, 4,2, 1,1);
        add(0,1,0,0, 2,2, 2,1);
        add(0,1,1,0, 3,2, 3,1);
        add(1,1,1,0, 0,0, 0,0);
        add(0,1,1,0, 1,0, 1,0);
        add(1,0,0,0, 0,0, 0,0);
        add(0,1,1,0, 1,0, 1,0);
        add(0,1,0,0, 2,0, 2,0);
        add(0,1,1,0, 3,0, 3,0);
        add(0,0,1,0, 3,0, 3,0);
        add(0,0,1,0, 3,0, 3,0);
        add(0,0,1,0, 3,0, 3,0);
        add(0,1,0,0, 2,0, 2,0);
        add(0,1,1,0, 3,0, 3,0);
        add(0,1,1,0, 4,1, 4,1);
        add(0,0,1,0, 4,1, 4,1);
        add(0,1,0,1, 2,0, 0,0);

        foreach (tbl[v]) begin
            step(tbl[v].r, tbl[v].e, tbl[v].b, tbl[v].c);
            check($sformatf("vec%0d u0 state", v), d_state(0), 32'(tbl[v].s0));
            check($sformatf("vec%0d u0 match", v), d_match(0), 32'(tbl[v].s0 == 4));
            check($sformatf("vec%0d u0 cnt", v),   d_cnt(0),   32'(tbl[v].n0));
            check($sformatf("vec%0d u1 state", v), d_state(1), 32'(tbl[v].s1));
            check($sformatf("vec%0d u1 match", v), d_match(1), 32'(tbl[v].s1 == 4));
            check($sformatf("vec%0d u1 cnt", v),   d_cnt(1),   32'(tbl[v].n1));
        end

        // All-ones pattern: stays full once reached, counts every edge, 2-bit counter saturates.
        step(1, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            step(0, 1, 1, 0);
            check($sformatf("ones%0d u2 state", i), d_state(2), 32'((i < 4) ? i : 4));
            check($sformatf("ones%0d u2 cnt", i),   d_cnt(2),   32'((i < 4) ? 0 : i - 3));
            check($sformatf("ones%0d u3 cnt", i),   d_cnt(3),   32'((i < 4) ? 0 : ((i - 3 > 3) ? 3 : i - 3)));
        end
        step(0, 1, 1, 1);
        check("clr vs inc u2 cnt",   d_cnt(2),   32'd0);
        check("clr vs inc u3 cnt",   d_cnt(3),   32'd0);
        check("clr keeps u2 state",  d_state(2), 32'd4);
        check("clr keeps u2 match",  d_match(2), 32'd1);
        step(0, 1, 1, 0);
        check("after clr u2 cnt",    d_cnt(2),   32'd1);
        step(0, 1, 0, 0);
        check("ones broken u2 state", d_state(2), 32'd0);
        check("ones broken u2 match", d_match(2), 32'd0);

        // Randomized streams against the reference model on every instance.
        step(1, 0, 0, 0);
        for (int n = 0; n < 2000; n++) begin
            step(($urandom_range(199) == 0), ($urandom_range(3) != 0),
                 bit'($urandom_range(1)), ($urandom_range(49) == 0));
            for (int i = 0; i < NDUT; i++) begin
                check($sformatf("rnd%0d u%0d state", n, i), d_state(i), 32'(m_state[i]));
                check($sformatf("rnd%0d u%0d match", n, i), d_match(i), 32'(m_state[i] == cfg_len(i)));
                check($sformatf("rnd%0d u%0d cnt", n, i),   d_cnt(i),   32'(m_cnt[i]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
